// File: rtl/uart_cmd_ctrl.sv
// UART command parser: pops cmd/data bytes from RX FIFO, drives one-cycle reg read/write strobes, returns read data (or write ack) to TX FIFO.
// Read: o_rd_req at pop+1, o_tx_wr at pop+3; write: o_wr_req one cycle after data pop; a full TX FIFO holds the response in PUSH, nothing dropped.
module uart_cmd_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter bit          WR_ACK_EN      = 1'b0,
    parameter logic [7:0]  ACK_BYTE       = 8'hA5
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_fifo_e,
    output logic       o_rx_rd,
    output logic [2:0] o_rwaddr,
    output logic [7:0] o_write_data,
    output logic       o_wr_req,
    output logic       o_rd_req,
    input  logic [7:0] i_read_data,
    output logic [7:0] o_tx_data,
    output logic       o_tx_wr,
    input  logic       i_tx_fifo_f,
    output logic       o_busy,
    output logic [7:0] o_err_cnt
);

    localparam int unsigned TW   = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_GET_DATA, S_WRITE, S_READ, S_WAIT_RD, S_PUSH
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q;
    logic          cmd_ld, data_ld, rsp_rd_ld, rsp_ack_ld;
    logic          tmr_clr, tmr_inc, err_inc;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            o_rwaddr     <= '0;
            o_write_data <= '0;
            o_tx_data    <= '0;
            o_err_cnt    <= '0;
            timer_q      <= '0;
        end else begin
            state_q <= state_d;
            if (cmd_ld)
                o_rwaddr <= i_rx_data[2:0];
            if (data_ld)
                o_write_data <= i_rx_data;
            // o_tx_data is the response register itself
            if (rsp_rd_ld)
                o_tx_data <= i_read_data;
            else if (rsp_ack_ld)
                o_tx_data <= ACK_BYTE;
            if (tmr_clr)
                timer_q <= '0;
            else if (tmr_inc)
                timer_q <= timer_q + 1'b1;
            if (err_inc && o_err_cnt != 8'hFF)
                o_err_cnt <= o_err_cnt + 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        o_rx_rd    = 1'b0;
        o_wr_req   = 1'b0;
        o_rd_req   = 1'b0;
        o_tx_wr    = 1'b0;
        cmd_ld     = 1'b0;
        data_ld    = 1'b0;
        rsp_rd_ld  = 1'b0;
        rsp_ack_ld = 1'b0;
        tmr_clr    = 1'b0;
        tmr_inc    = 1'b0;
        err_inc    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!i_rx_fifo_e) begin
                    o_rx_rd = 1'b1;
                    if (i_rx_data[6:3] != 4'b0000) begin
                        err_inc = 1'b1;
                    end else begin
                        cmd_ld = 1'b1;
                        if (i_rx_data[7]) begin
                            state_d = S_GET_DATA;
                            tmr_clr = 1'b1;
                        end else begin
                            state_d = S_READ;
                        end
                    end
                end
            end
            S_GET_DATA: begin
                // a data byte beats a simultaneous timeout
                if (!i_rx_fifo_e) begin
                    o_rx_rd = 1'b1;
                    data_ld = 1'b1;
                    state_d = S_WRITE;
                end else if (timer_q == TMAX) begin
                    err_inc = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            S_WRITE: begin
                o_wr_req = 1'b1;
                if (WR_ACK_EN) begin
                    rsp_ack_ld = 1'b1;
                    state_d    = S_PUSH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                o_rd_req = 1'b1;
                state_d  = S_WAIT_RD;
            end
            S_WAIT_RD: begin
                rsp_rd_ld = 1'b1;
                state_d   = S_PUSH;
            end
            S_PUSH: begin
                if (!i_tx_fifo_f) begin
                    o_tx_wr = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: a cycle table for write/read/backpressure/timeout cases,
// then hand-written saturation, reset-mid-command and write-ack sequences.
module tb_uart_cmd_ctrl;

    logic       clk = 1'b0;
    logic       i_rst;
    logic [7:0] i_rx_data;
    logic       i_rx_fifo_e;
    logic [7:0] i_read_data;
    logic       i_tx_fifo_f;

    logic       o_rx_rd, o_wr_req, o_rd_req, o_tx_wr, o_busy;
    logic [2:0] o_rwaddr;
    logic [7:0] o_write_data, o_tx_data, o_err_cnt;

    logic       a_rx_rd, a_wr_req, a_rd_req, a_tx_wr, a_busy;
    logic [2:0] a_rwaddr;
    logic [7:0] a_write_data, a_tx_data, a_err_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    uart_cmd_ctrl #(.TIMEOUT_CYCLES(16), .WR_ACK_EN(1'b0), .ACK_BYTE(8'hA5)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_rx_data(i_rx_data), .i_rx_fifo_e(i_rx_fifo_e),
        .o_rx_rd(o_rx_rd), .o_rwaddr(o_rwaddr), .o_write_data(o_write_data),
        .o_wr_req(o_wr_req), .o_rd_req(o_rd_req), .i_read_data(i_read_data),
        .o_tx_data(o_tx_data), .o_tx_wr(o_tx_wr), .i_tx_fifo_f(i_tx_fifo_f),
        .o_busy(o_busy), .o_err_cnt(o_err_cnt)
    );

    uart_cmd_ctrl #(.TIMEOUT_CYCLES(16), .WR_ACK_EN(1'b1), .ACK_BYTE(8'hA5)) dut_ack (
        .i_clk(clk), .i_rst(i_rst), .i_rx_data(i_rx_data), .i_rx_fifo_e(i_rx_fifo_e),
        .o_rx_rd(a_rx_rd), .o_rwaddr(a_rwaddr), .o_write_data(a_write_data),
        .o_wr_req(a_wr_req), .o_rd_req(a_rd_req), .i_read_data(i_read_data),
        .o_tx_data(a_tx_data), .o_tx_wr(a_tx_wr), .i_tx_fifo_f(i_tx_fifo_f),
        .o_busy(a_busy), .o_err_cnt(a_err_cnt)
    );

    typedef struct {
        logic        rx_e;
        logic [7:0]  rx_d;
        logic        tx_f;
        logic [7:0]  rd_d;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    // packed output view: {rx_rd, wr, rd, tx_wr, tx_data, rwaddr, write_data, busy, err_cnt}
    function automatic logic [31:0] outs(input logic rxr, input logic wr, input logic rd,
                                         input logic tw, input logic [7:0] txd,
                                         input logic [2:0] a, input logic [7:0] wd,
                                         input logic b, input logic [7:0] er);
        return {rxr, wr, rd, tw, txd, a, wd, b, er};
    endfunction

    task automatic add(input logic e, input logic [7:0] d, input logic tf,
                       input logic [7:0] rdd, input logic [31:0] x);
        vec_t v;
        v.rx_e = e; v.rx_d = d; v.tx_f = tf; v.rd_d = rdd; v.exp = x;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic strobe_seen;
        int   pops;

        // write CR: 0x80, 0x03 back to back
        add(1, 8'h00, 0, 8'h00, outs(0,0,0,0,8'h00,3'd0,8'h00,0,8'd0));
        add(0, 8'h80, 0, 8'h00, outs(1,0,0,0,8'h00,3'd0,8'h00,0,8'd0));
        add(0, 8'h03, 0, 8'h00, outs(1,0,0,0,8'h00,3'd0,8'h00,1,8'd0));
        add(1, 8'h00, 0, 8'h00, outs(0,1,0,0,8'h00,3'd0,8'h03,1,8'd0));
        add(1, 8'h00, 0, 8'h00, outs(0,0,0,0,8'h00,3'd0,8'h03,0,8'd0));
        // read SR: 0x01, read data 0x5C
        add(0, 8'h01, 0, 8'h00, outs(1,0,0,0,8'h00,3'd0,8'h03,0,8'd0));
        add(1, 8'h00, 0, 8'h00, outs(0,0,1,0,8'h00,3'd1,8'h03,1,8'd0));
        add(1, 8'h00, 0, 8'h5C, outs(0,0,0,0,8'h00,3'd1,8'h03,1,8'd0));
        add(1, 8'h00, 0, 8'h00, outs(0,0,0,1,8'h5C,3'd1,8'h03,1,8'd0));
        add(1, 8'h00, 0, 8'h00, outs(0,0,0,0,8'h5C,3'd1,8'h03,0,8'd0));
        // read with TX full for 10 cycles while RX holds a byte that must not be popped
        add(0, 8'h02, 0, 8'h00, outs(1,0,0,0,8'h5C,3'd1,8'h03,0,8'd0));
        add(1, 8'h00, 1, 8'h00, outs(0,0,1,0,8'h5C,3'd2,8'h03,1,8'd0));
        add(1, 8'h00, 1, 8'hE7, outs(0,0,0,0,8'h5C,3'd2,8'h03,1,8'd0));
        for (int i = 0; i < 10; i++)
            add(0, 8'h01, 1, 8'h00, outs(0,0,0,0,8'hE7,3'd2,8'h03,1,8'd0));
        add(1, 8'h00, 0, 8'h00, outs(0,0,0,1,8'hE7,3'd2,8'h03,1,8'd0));
        add(1, 8'h00, 0, 8'h00, outs(0,0,0,0,8'hE7,3'd2,8'h03,0,8'd0));
        // malformed command
        add(0, 8'h48, 0, 8'h00, outs(1,0,0,0,8'hE7,3'd2,8'h03,0,8'd0));
        add(1, 8'h00, 0, 8'h00, outs(0,0,0,0,8'hE7,3'd2,8'h03,0,8'd1));
        // write whose data arrives on the last timer cycle
        add(0, 8'h85, 0, 8'h00, outs(1,0,0,0,8'hE7,3'd2,8'h03,0,8'd1));
        for (int i = 0; i < 15; i++)
            add(1, 8'h00, 0, 8'h00, outs(0,0,0,0,8'hE7,3'd5,8'h03,1,8'd1));
        add(0, 8'hC3, 0, 8'h00, outs(1,0,0,0,8'hE7,3'd5,8'h03,1,8'd1));
        add(1, 8'h00, 0, 8'h00, outs(0,1,0,0,8'hE7,3'd5,8'hC3,1,8'd1));
        add(1, 8'h00, 0, 8'h00, outs(0,0,0,0,8'hE7,3'd5,8'hC3,0,8'd1));
        // write 0x82 with no data: aborts after 16 cycles, then a read follows
        add(0, 8'h82, 0, 8'h00, outs(1,0,0,0,8'hE7,3'd5,8'hC3,0,8'd1));
        for (int i = 0; i < 16; i++)
            add(1, 8'h00, 0, 8'h00, outs(0,0,0,0,8'hE7,3'd2,8'hC3,1,8'd1));
        for (int i = 0; i < 4; i++)
            add(1, 8'h00, 0, 8'h00, outs(0,0,0,0,8'hE7,3'd2,8'hC3,0,8'd2));
        add(0, 8'h01, 0, 8'h00, outs(1,0,0,0,8'hE7,3'd2,8'hC3,0,8'd2));
        add(1, 8'h00, 0, 8'h00, outs(0,0,1,0,8'hE7,3'd1,8'hC3,1,8'd2));
        add(1, 8'h00, 0, 8'h11, outs(0,0,0,0,8'hE7,3'd1,8'hC3,1,8'd2));
        add(1, 8'h00, 0, 8'h00, outs(0,0,0,1,8'h11,3'd1,8'hC3,1,8'd2));
        add(1, 8'h00, 0, 8'h00, outs(0,0,0,0,8'h11,3'd1,8'hC3,0,8'd2));

        i_rst = 1'b1; i_rx_fifo_e = 1'b1; i_rx_data = 8'h00;
        i_read_data = 8'h00; i_tx_fifo_f = 1'b0;
        repeat (2) @(negedge clk);
        i_rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            i_rx_fifo_e = vecs[i].rx_e;
            i_rx_data   = vecs[i].rx_d;
            i_tx_fifo_f = vecs[i].tx_f;
            i_read_data = vecs[i].rd_d;
            #1;
            check($sformatf("vec%0d", i),
                  {o_rx_rd, o_wr_req, o_rd_req, o_tx_wr, o_tx_data, o_rwaddr,
                   o_write_data, o_busy, o_err_cnt}, vecs[i].exp);
        end

        // 300 malformed bytes back to back: counter climbs from 2 and saturates
        @(negedge clk);
        i_rx_fifo_e = 1'b0; i_rx_data = 8'h48; i_tx_fifo_f = 1'b0; i_read_data = 8'h00;
        strobe_seen = 1'b0; pops = 0;
        for (int k = 0; k < 300; k++) begin
            #1;
            strobe_seen = strobe_seen | o_wr_req | o_rd_req | o_tx_wr;
            if (o_rx_rd) pops++;
            if (k == 252) check("sat_254", 32'(o_err_cnt), 32'd254);
            @(negedge clk);
        end
        i_rx_fifo_e = 1'b1;
        #1;
        check("sat_255", 32'(o_err_cnt), 32'd255);
        check("sat_pops", 32'(pops), 32'd300);
        check("sat_no_strobes", 32'(strobe_seen), 32'd0);

        // reset while waiting for write data
        @(negedge clk);
        i_rx_fifo_e = 1'b0; i_rx_data = 8'h83;
        @(negedge clk);
        i_rx_fifo_e = 1'b1;
        #1;
        check("rst_mid_busy", 32'(o_busy), 32'd1);
        @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        #1;
        check("rst_mid_outputs",
              {o_rx_rd, o_wr_req, o_rd_req, o_tx_wr, o_tx_data, o_rwaddr,
               o_write_data, o_busy, o_err_cnt}, 32'd0);
        // a byte after reset is a fresh command (0x10 is malformed), never write data
        @(negedge clk);
        i_rx_fifo_e = 1'b0; i_rx_data = 8'h10;
        #1;
        check("rst_next_pop", {31'd0, o_rx_rd}, 32'd1);
        @(negedge clk);
        i_rx_fifo_e = 1'b1;
        strobe_seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            strobe_seen = strobe_seen | o_wr_req | o_tx_wr;
            @(negedge clk);
        end
        check("rst_no_write", 32'(strobe_seen), 32'd0);
        check("rst_after_state", {o_busy, o_write_data, o_err_cnt}, {15'd0, 1'b0, 8'h00, 8'd1});

        // write with acknowledge enabled
        i_rx_fifo_e = 1'b0; i_rx_data = 8'h84;
        @(negedge clk);
        i_rx_data = 8'h10;
        @(negedge clk);
        i_rx_fifo_e = 1'b1;
        #1;
        check("ack_wr", {a_wr_req, a_tx_wr, a_rwaddr, a_write_data}, {19'd0, 1'b1, 1'b0, 3'd4, 8'h10});
        @(negedge clk);
        #1;
        check("ack_push", {a_tx_wr, a_tx_data}, {23'd0, 1'b1, 8'hA5});
        check("noack_no_push", {o_tx_wr, o_busy}, 32'd0);
        @(negedge clk);
        #1;
        check("ack_idle", {a_busy, a_tx_wr}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
- Byte-level command parser between the UART RX/TX FIFOs and the register file.
- Pops command bytes from the RX FIFO and issues single-cycle write/read requests (address, data) to the register file.
- Returns read data (and optional write acknowledges) to the TX FIFO, so a host PC can configure the algorithm and stream ECG samples over UART.

Parameters:
- TIMEOUT_CYCLES, 100000: cycles allowed between a write command byte and its data byte before the command is aborted; must be >= 2.
- WR_ACK_EN, 0: when 1, every completed write pushes ACK_BYTE to the TX FIFO.
- ACK_BYTE, 8'hA5: byte pushed as write acknowledge.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous reset, active-high
- i_rx_data  in  8  RX FIFO head byte, first-word-fall-through, valid while i_rx_fifo_e=0
- i_rx_fifo_e  in  1  RX FIFO empty
- o_rx_rd  out  1  RX FIFO pop strobe
- o_rwaddr  out  3  register offset
- o_write_data  out  8  register write data
- o_wr_req  out  1  register write strobe
- o_rd_req  out  1  register read strobe
- i_read_data  in  8  register read data; valid the cycle after o_rd_req
- o_tx_data  out  8  byte to TX FIFO
- o_tx_wr  out  1  TX FIFO push strobe
- i_tx_fifo_f  in  1  TX FIFO full
- o_busy  out  1  state != IDLE
- o_err_cnt  out  8  saturating protocol error counter

Behaviour:
- Clock and reset: one clock, i_clk; i_rst is synchronous and active-high.
- Reset values: state IDLE; all strobes 0; o_rwaddr, o_write_data, o_tx_data, o_err_cnt, timer and response register all 0.
- Command byte format:
  - bit7 = 1 write, 0 read.
  - bits6:3 must be 0000.
  - bits2:0 = register offset.
- All strobes are decoded from the registered state only: no combinational path from i_rx_data, i_rx_fifo_e or i_tx_fifo_f to o_wr_req or o_rd_req.
- o_rx_rd is the exception: it is asserted only in IDLE/GET_DATA while i_rx_fifo_e=0, so it may depend combinationally on i_rx_fifo_e.
- FSM states:
  - IDLE: if !i_rx_fifo_e, pop and latch the command.
    - bits6:3 != 0: increment o_err_cnt, stay IDLE.
    - Write: go to GET_DATA, clear the timer.
    - Read: go to READ.
  - GET_DATA: if !i_rx_fifo_e, pop, latch o_write_data, go to WRITE. Otherwise increment the timer.
    - When timer == TIMEOUT_CYCLES-1: increment o_err_cnt, go to IDLE; no write is issued.
  - WRITE: o_wr_req=1 for exactly one cycle. Go to PUSH with the response = ACK_BYTE if WR_ACK_EN, else go to IDLE.
  - READ: o_rd_req=1 for exactly one cycle, go to WAIT_RD.
  - WAIT_RD: latch i_read_data into the response register, go to PUSH.
  - PUSH: if !i_tx_fifo_f, o_tx_wr=1 with o_tx_data=response, go to IDLE. Otherwise hold; no byte is dropped.
- o_rwaddr holds the latched offset from command acceptance until the next command is accepted.
- Latency with the command popped at cycle T:
  - Read: o_rd_req at T+1, o_tx_wr at T+3 if TX not full.
  - Write: data popped at T+1 at the earliest, o_wr_req at T+2.
- Only one command is in flight. No RX pop occurs in WRITE, READ, WAIT_RD or PUSH.
- o_err_cnt saturates at 255 and is cleared only by reset.
- Boundary cases:
  - RX empty in IDLE: no pop, no strobes.
  - Timeout counting restarts per write command.
  - A data byte arriving on the same cycle the timer reaches TIMEOUT_CYCLES-1 is accepted; data wins over timeout.
  - Reset mid-command (any state) discards the partial command: no write or push is issued after reset.

Test Plan:
- Write CR: RX bytes 8'h80, 8'h03 back-to-back -> o_wr_req one cycle, o_rwaddr=0, o_write_data=8'h03, two o_rx_rd pulses, no o_tx_wr (WR_ACK_EN=0).
- Read SR: RX 8'h01, i_read_data=8'h5C the cycle after o_rd_req -> o_rd_req at T+1 with o_rwaddr=1, o_tx_wr at T+3 with o_tx_data=8'h5C.
- TX backpressure: read command with i_tx_fifo_f=1 for 10 cycles -> o_tx_wr stays 0 and o_busy=1; single push of the correct byte after full deasserts.
- Timeout: TIMEOUT_CYCLES=16, RX 8'h82 then nothing for 20 cycles -> no o_wr_req, o_err_cnt=1, o_busy=0; next byte 8'h01 is treated as a new read command.
- Malformed command and saturation: RX 8'h48 -> no strobes, o_err_cnt increments. 300 such bytes -> o_err_cnt=255.
- Reset mid-command and ack mode:
  - i_rst asserted in GET_DATA after 8'h83 -> no write, all outputs reset values.
  - With WR_ACK_EN=1, write 8'h84, 8'h10 -> o_wr_req then o_tx_data=8'hA5 pushed.
